qcs_dyn_pre_gen_rsp: RTL and testbench

Responder end of the qcs_dyn_pre_gen interface. It accepts nhtp_re/nhtp_raddr read requests plus the per-packet TX configuration, and returns frequency-domain non-HT L-LTF tone samples. Each sample is 20 MHz-duplicated across active subbands, gamma-rotated per subband, masked for puncturing, and scaled for the TX chain count. It sits between the TX config register block and the preamble IFFT feeder.

---
 rtl/qcs_dyn_pre_gen_pkg.sv | 22 ++
 rtl/qcs_dyn_pre_gen_ltf_rom.sv | 41 ++++
 rtl/qcs_dyn_pre_gen_rsp.sv | 162 ++++++++++++++++
 tb/tb_qcs_dyn_pre_gen_rsp.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qcs_dyn_pre_gen_pkg.sv
// Shared types, constants and helpers for the qcs_dyn_pre_gen responder.
package qcs_dyn_pre_gen_pkg;

   typedef enum logic [1:0] {BW_20 = 2'd0, BW_40 = 2'd1, BW_80 = 2'd2, BW_RSV = 2'd3} bw_e;
   typedef enum logic [1:0] {GAMMA_P1 = 2'd0, GAMMA_PJ = 2'd1, GAMMA_M1 = 2'd2, GAMMA_MJ = 2'd3} gamma_e;
   typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DRAIN} state_e;

   localparam int unsigned LTF_AMP = 1024;

   // L-LTF sign table, bit set = -LTF_AMP. POS: tones 1..26 (bit 0 = tone 1).
   // NEG: tones 38..63, i.e. subcarriers -26..-1 (bit 0 = tone 38).
   localparam logic [25:0] LTF_POS_NEG = 26'b0000_1010_1100_1111_1010_1001_10;
   localparam logic [25:0] LTF_NEG_NEG = 26'b0000_1010_0110_0000_0101_0011_00;

   function automatic logic [1:0] ntx_shift(input logic [3:0] n);
      if (n >= 4'd8)      return 2'd3;
      else if (n >= 4'd4) return 2'd2;
      else if (n >= 4'd2) return 2'd1;
      else                return 2'd0;
   endfunction

endpackage

// File: rtl/qcs_dyn_pre_gen_ltf_rom.sv
// 64-entry registered non-HT L-LTF tone table; real-valued, so only I is produced.
module qcs_dyn_pre_gen_ltf_rom
   import qcs_dyn_pre_gen_pkg::*;
#(
   parameter int SAMPLE_W = 12
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic [5:0]                 i_tone,
   output logic signed [SAMPLE_W-1:0] o_i
);

   localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(LTF_AMP);

   logic [5:0]                 w_pos_idx;
   logic [5:0]                 w_neg_idx;
   logic                       w_neg;
   logic                       w_zero;
   logic signed [SAMPLE_W-1:0] w_i;

   always_comb begin
      w_pos_idx = i_tone - 6'd1;
      w_neg_idx = i_tone - 6'd38;
      w_neg     = 1'b0;
      w_zero    = 1'b0;
      if (i_tone >= 6'd1 && i_tone <= 6'd26) begin
         w_neg = LTF_POS_NEG[w_pos_idx[4:0]];
      end else if (i_tone >= 6'd38) begin
         w_neg = LTF_NEG_NEG[w_neg_idx[4:0]];
      end else begin
         w_zero = 1'b1;
      end
      w_i = w_zero ? '0 : (w_neg ? -AMP : AMP);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) o_i <= '0;
      else          o_i <= w_i;
   end

endmodule

// File: rtl/qcs_dyn_pre_gen_rsp.sv
// Responder for qcs_dyn_pre_gen: 2-stage L-LTF tone reader with duplication, gamma, puncture and n_tx scaling.
// Optional read counter output rd_cnt enabled by `define QCS_DYN_PRE_GEN_RSP_STATS_EN.
module qcs_dyn_pre_gen_rsp
   import qcs_dyn_pre_gen_pkg::*;
#(
   parameter int ADDR_DW   = 8,
   parameter int BW_W      = 2,
   parameter int GAMMA_W   = 8,
   parameter int SUBBAND_W = 4,
   parameter int SAMPLE_W  = 12
) (
`ifdef QCS_DYN_PRE_GEN_RSP_STATS_EN
   output logic [15:0]                rd_cnt,
`endif
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       nhtp_re,
   input  logic [ADDR_DW-1:0]         nhtp_raddr,
   input  logic [BW_W-1:0]            txconfig_bw,
   input  logic [BW_W-1:0]            sys_bw_mode,
   input  logic [SUBBAND_W-1:0]       config_mu_subband_present,
   input  logic [GAMMA_W-1:0]         config_gamma_rotation,
   input  logic [3:0]                 n_tx,
   input  logic                       nhtp_4ch,
   output logic                       nhtp_rvalid,
   output logic signed [SAMPLE_W-1:0] nhtp_rdata_i,
   output logic signed [SAMPLE_W-1:0] nhtp_rdata_q,
   output logic                       addr_err,
   output logic                       cfg_err
);

   localparam int SB_W = ADDR_DW - 6;

   state_e                r_state;
   logic                  r_drain_last;
   bw_e                   r_bw;
   logic [SUBBAND_W-1:0]  r_mask;
   logic [GAMMA_W-1:0]    r_gamma;
   logic [1:0]            r_shift;
   logic                  r_cfg_err;

   logic                  r_v1;
   logic [SB_W-1:0]       r_sb1;
   logic signed [SAMPLE_W-1:0] w_rom_i;

   logic [BW_W-1:0]       w_eff_bw;
   logic                  w_cfg_bad;

   always_comb begin
      w_eff_bw  = nhtp_4ch ? BW_W'(BW_80) : txconfig_bw;
      w_cfg_bad = (txconfig_bw == BW_W'(BW_RSV)) || (sys_bw_mode == BW_W'(BW_RSV)) ||
                  (w_eff_bw > sys_bw_mode);
   end

   // Config is only sampled on the IDLE->ACTIVE edge; DRAIN re-entry keeps it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_drain_last <= 1'b0;
         r_bw         <= BW_20;
         r_mask       <= '0;
         r_gamma      <= '0;
         r_shift      <= '0;
         r_cfg_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: if (nhtp_re) begin
               r_state   <= ST_ACTIVE;
               r_bw      <= bw_e'(w_eff_bw);
               r_mask    <= config_mu_subband_present;
               r_gamma   <= config_gamma_rotation;
               r_shift   <= ntx_shift(n_tx);
               r_cfg_err <= w_cfg_bad;
            end
            ST_ACTIVE: if (!nhtp_re) begin
               r_state      <= ST_DRAIN;
               r_drain_last <= 1'b0;
            end
            ST_DRAIN: begin
               if (nhtp_re)           r_state      <= ST_ACTIVE;
               else if (r_drain_last) r_state      <= ST_IDLE;
               else                   r_drain_last <= 1'b1;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   qcs_dyn_pre_gen_ltf_rom #(
      .SAMPLE_W (SAMPLE_W)
   ) u_rom (
      .clk     (clk),
      .reset_n (reset_n),
      .i_tone  (nhtp_raddr[5:0]),
      .o_i     (w_rom_i)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v1  <= 1'b0;
         r_sb1 <= '0;
      end else begin
         r_v1  <= nhtp_re;
         r_sb1 <= nhtp_raddr[ADDR_DW-1:6];
      end
   end

   logic [2:0]                 w_act_sb;
   logic                       w_addr_bad;
   logic                       w_kill;
   gamma_e                     w_gamma;
   logic signed [SAMPLE_W-1:0] w_src_q;
   logic signed [SAMPLE_W-1:0] w_rot_i;
   logic signed [SAMPLE_W-1:0] w_rot_q;
   logic signed [SAMPLE_W-1:0] w_sc_i;
   logic signed [SAMPLE_W-1:0] w_sc_q;

   always_comb begin
      case (r_bw)
         BW_20:   w_act_sb = 3'd1;
         BW_40:   w_act_sb = 3'd2;
         default: w_act_sb = 3'd4;
      endcase
      w_addr_bad = {1'b0, r_sb1} >= w_act_sb;
      w_kill     = w_addr_bad || !r_mask[r_sb1] || r_cfg_err;
      w_gamma    = gamma_e'(r_gamma[{r_sb1, 1'b0} +: 2]);
      w_src_q    = '0;
      case (w_gamma)
         GAMMA_PJ: begin w_rot_i = -w_src_q; w_rot_q =  w_rom_i; end
         GAMMA_M1: begin w_rot_i = -w_rom_i; w_rot_q = -w_src_q; end
         GAMMA_MJ: begin w_rot_i =  w_src_q; w_rot_q = -w_rom_i; end
         default:  begin w_rot_i =  w_rom_i; w_rot_q =  w_src_q; end
      endcase
      w_sc_i = w_rot_i >>> r_shift;
      w_sc_q = w_rot_q >>> r_shift;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nhtp_rvalid  <= 1'b0;
         nhtp_rdata_i <= '0;
         nhtp_rdata_q <= '0;
         addr_err     <= 1'b0;
      end else begin
         nhtp_rvalid  <= r_v1;
         addr_err     <= r_v1 && w_addr_bad;
         nhtp_rdata_i <= (r_v1 && !w_kill) ? w_sc_i : '0;
         nhtp_rdata_q <= (r_v1 && !w_kill) ? w_sc_q : '0;
      end
   end

   assign cfg_err = r_cfg_err;

`ifdef QCS_DYN_PRE_GEN_RSP_STATS_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                          rd_cnt <= '0;
      else if (nhtp_re && r_state == ST_IDLE) rd_cnt <= 16'd1;
      else if (nhtp_re && rd_cnt != '1)      rd_cnt <= rd_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_qcs_dyn_pre_gen_rsp.sv
// Self-checking bench for qcs_dyn_pre_gen_rsp: directed vector table, long burst, random traffic, mid-burst reset.
module tb_qcs_dyn_pre_gen_rsp;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              nhtp_re;
   logic [7:0]        nhtp_raddr;
   logic [1:0]        txconfig_bw;
   logic [1:0]        sys_bw_mode;
   logic [3:0]        config_mu_subband_present;
   logic [7:0]        config_gamma_rotation;
   logic [3:0]        n_tx;
   logic              nhtp_4ch;
   logic              nhtp_rvalid;
   logic signed [11:0] nhtp_rdata_i;
   logic signed [11:0] nhtp_rdata_q;
   logic              addr_err;
   logic              cfg_err;
`ifdef QCS_DYN_PRE_GEN_RSP_STATS_EN
   logic [15:0]       rd_cnt;
`endif

   always #5 clk = ~clk;

   qcs_dyn_pre_gen_rsp #(
      .ADDR_DW   (8),
      .BW_W      (2),
      .GAMMA_W   (8),
      .SUBBAND_W (4),
      .SAMPLE_W  (12)
   ) dut (
`ifdef QCS_DYN_PRE_GEN_RSP_STATS_EN
      .rd_cnt                    (rd_cnt),
`endif
      .clk                       (clk),
      .reset_n                   (reset_n),
      .nhtp_re                   (nhtp_re),
      .nhtp_raddr                (nhtp_raddr),
      .txconfig_bw               (txconfig_bw),
      .sys_bw_mode               (sys_bw_mode),
      .config_mu_subband_present (config_mu_subband_present),
      .config_gamma_rotation     (config_gamma_rotation),
      .n_tx                      (n_tx),
      .nhtp_4ch                  (nhtp_4ch),
      .nhtp_rvalid               (nhtp_rvalid),
      .nhtp_rdata_i              (nhtp_rdata_i),
      .nhtp_rdata_q              (nhtp_rdata_q),
      .addr_err                  (addr_err),
      .cfg_err                   (cfg_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic signed [31:0] act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Subcarriers -26..26 of the 802.11 L-LTF.
   int LTF [53] = '{1,1,-1,-1,1,1,-1,1,-1,1,1,1,1,1,1,-1,-1,1,1,-1,1,-1,1,1,1,1,
                    0,
                    1,-1,-1,1,1,-1,1,-1,1,-1,-1,-1,-1,-1,1,1,-1,-1,1,-1,1,-1,1,1,1,1};

   typedef struct {
      bit v;
      int i;
      int q;
      int aerr;
   } beat_t;

   beat_t pipe[$];
   bit    m_seen;
   int    m_gap;
   int    m_cnt;
   int    m_cfg;
   int    m_eff;
   int    m_mask;
   int    m_gamma;
   int    m_shift;

   function automatic void model_reset();
      beat_t b;
      b = '{v: 1'b0, i: 0, q: 0, aerr: 0};
      pipe.delete();
      pipe.push_back(b);
      m_seen = 1'b0;
      m_gap  = 0;
      m_cnt  = 0;
      m_cfg  = 0;
   endfunction

   function automatic beat_t model_beat(input int addr);
      beat_t b;
      int sb, t, k, amp, ri, rq, tmp, g, act;
      sb  = addr / 64;
      t   = addr % 64;
      k   = (t <= 26) ? t : t - 64;
      amp = (k >= -26 && k <= 26) ? LTF[k + 26] * 1024 : 0;
      ri  = amp;
      rq  = 0;
      g   = (m_gamma >> (2 * sb)) & 3;
      for (int n = 0; n < g; n++) begin
         tmp = ri;
         ri  = -rq;
         rq  = tmp;
      end
      ri  = ri >>> m_shift;
      rq  = rq >>> m_shift;
      act = (m_eff == 0) ? 1 : (m_eff == 1) ? 2 : 4;
      b.v    = 1'b1;
      b.aerr = (sb >= act) ? 1 : 0;
      if (b.aerr == 1 || ((m_mask >> sb) & 1) == 0 || m_cfg == 1) begin
         ri = 0;
         rq = 0;
      end
      b.i = ri;
      b.q = rq;
      return b;
   endfunction

   // One cycle: drive at negedge, update model, sample #1 after posedge.
   task automatic step(input logic re_v, input logic [7:0] a);
      beat_t cur, exp_b;
      int    ntx;
      @(negedge clk);
      nhtp_re    = re_v;
      nhtp_raddr = a;
      if (re_v) begin
         if (!m_seen || m_gap >= 3) begin
            m_eff   = nhtp_4ch ? 2 : int'(txconfig_bw);
            m_cfg   = (txconfig_bw == 2'd3 || sys_bw_mode == 2'd3 || m_eff > int'(sys_bw_mode)) ? 1 : 0;
            m_mask  = int'(config_mu_subband_present);
            m_gamma = int'(config_gamma_rotation);
            ntx     = (n_tx == 4'd0) ? 1 : int'(n_tx);
            m_shift = (ntx == 1) ? 0 : (ntx < 4) ? 1 : (ntx < 8) ? 2 : 3;
            m_cnt   = 1;
         end else if (m_cnt < 65535) begin
            m_cnt++;
         end
         m_seen = 1'b1;
         m_gap  = 0;
         cur    = model_beat(int'(a));
      end else begin
         if (m_gap < 100) m_gap++;
         cur = '{v: 1'b0, i: 0, q: 0, aerr: 0};
      end
      pipe.push_back(cur);
      @(posedge clk);
      #1;
      exp_b = pipe.pop_front();
      chk("rvalid", nhtp_rvalid, exp_b.v);
      chk("addr_err", addr_err, exp_b.aerr);
      chk("cfg_err", cfg_err, m_cfg);
      if (exp_b.v) begin
         chk("rdata_i", nhtp_rdata_i, exp_b.i);
         chk("rdata_q", nhtp_rdata_q, exp_b.q);
      end
`ifdef QCS_DYN_PRE_GEN_RSP_STATS_EN
      chk("rd_cnt", rd_cnt, m_cnt);
`endif
   endtask

   task automatic rand_cfg();
      txconfig_bw               = 2'($urandom_range(0, 3));
      sys_bw_mode               = ($urandom % 2 == 0) ? 2'd2 : 2'($urandom_range(0, 3));
      config_mu_subband_present = 4'($urandom);
      config_gamma_rotation     = 8'($urandom);
      n_tx                      = 4'($urandom);
      nhtp_4ch                  = ($urandom % 4 == 0);
   endtask

   typedef struct {
      logic [7:0] addr;
      logic [1:0] tx;
      logic [1:0] sys;
      logic [3:0] mask;
      logic [7:0] gamma;
      logic [3:0] ntx;
      logic       ch4;
      int         ei;
      int         eq;
      int         eaerr;
      int         ecfg;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #20ms;
      $display("FAIL watchdog actual timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{8'h01, 2'd0, 2'd0, 4'hF, 8'h00, 4'd1,  1'b0,  1024,     0, 0, 0};
      tbl[1]  = '{8'h41, 2'd1, 2'd1, 4'hF, 8'h04, 4'd1,  1'b0,     0,  1024, 0, 0};
      tbl[2]  = '{8'h81, 2'd2, 2'd2, 4'hB, 8'h00, 4'd1,  1'b0,     0,     0, 0, 0};
      tbl[3]  = '{8'h81, 2'd0, 2'd2, 4'hF, 8'h00, 4'd1,  1'b0,     0,     0, 1, 0};
      tbl[4]  = '{8'h01, 2'd2, 2'd1, 4'hF, 8'h00, 4'd1,  1'b0,     0,     0, 0, 1};
      tbl[5]  = '{8'h01, 2'd0, 2'd0, 4'hF, 8'h00, 4'd4,  1'b0,   256,     0, 0, 0};
      tbl[6]  = '{8'h02, 2'd0, 2'd0, 4'hF, 8'h00, 4'd1,  1'b0, -1024,     0, 0, 0};
      tbl[7]  = '{8'hC2, 2'd0, 2'd2, 4'hF, 8'h80, 4'd2,  1'b1,   512,     0, 0, 0};
      tbl[8]  = '{8'h00, 2'd0, 2'd0, 4'hF, 8'h00, 4'd1,  1'b0,     0,     0, 0, 0};
      tbl[9]  = '{8'h1B, 2'd0, 2'd0, 4'hF, 8'h00, 4'd1,  1'b0,     0,     0, 0, 0};
      tbl[10] = '{8'h3F, 2'd0, 2'd0, 4'hF, 8'h03, 4'd15, 1'b0,     0,  -128, 0, 0};
      tbl[11] = '{8'h26, 2'd3, 2'd2, 4'hF, 8'h00, 4'd1,  1'b0,     0,     0, 0, 1};
      tbl[12] = '{8'h01, 2'd0, 2'd0, 4'hF, 8'h00, 4'd0,  1'b0,  1024,     0, 0, 0};
      tbl[13] = '{8'h41, 2'd0, 2'd1, 4'hF, 8'h00, 4'd1,  1'b1,     0,     0, 0, 1};

      reset_n    = 1'b0;
      nhtp_re    = 1'b0;
      nhtp_raddr = '0;
      rand_cfg();
      model_reset();
      #1;
      chk("rst_rvalid", nhtp_rvalid, 0);
      chk("rst_i", nhtp_rdata_i, 0);
      chk("rst_q", nhtp_rdata_q, 0);
      chk("rst_addr_err", addr_err, 0);
      chk("rst_cfg_err", cfg_err, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int v = 0; v < 14; v++) begin
         for (int n = 0; n < 4; n++) step(1'b0, 8'h00);
         txconfig_bw               = tbl[v].tx;
         sys_bw_mode               = tbl[v].sys;
         config_mu_subband_present = tbl[v].mask;
         config_gamma_rotation     = tbl[v].gamma;
         n_tx                      = tbl[v].ntx;
         nhtp_4ch                  = tbl[v].ch4;
         step(1'b1, tbl[v].addr);
         chk("tbl_early_rvalid", nhtp_rvalid, 0);
         rand_cfg();
         step(1'b0, 8'h00);
         chk("tbl_rvalid", nhtp_rvalid, 1);
         chk("tbl_i", nhtp_rdata_i, tbl[v].ei);
         chk("tbl_q", nhtp_rdata_q, tbl[v].eq);
         chk("tbl_addr_err", addr_err, tbl[v].eaerr);
         chk("tbl_cfg_err", cfg_err, tbl[v].ecfg);
      end

      // Long burst, one-cycle gap, re-entry with different config inputs.
      for (int n = 0; n < 4; n++) step(1'b0, 8'h00);
      txconfig_bw = 2'd2; sys_bw_mode = 2'd2; config_mu_subband_present = 4'hF;
      config_gamma_rotation = 8'h1B; n_tx = 4'd1; nhtp_4ch = 1'b0;
      for (int n = 0; n < 10336; n++) begin
         step(1'b1, 8'($urandom));
         rand_cfg();
      end
      step(1'b0, 8'h00);
`ifdef QCS_DYN_PRE_GEN_RSP_STATS_EN
      chk("rd_cnt_burst", rd_cnt, 10336);
`endif
      for (int n = 0; n < 6; n++) begin
         rand_cfg();
         step(1'b1, 8'($urandom));
      end

      for (int n = 0; n < 3000; n++) begin
         rand_cfg();
         step(($urandom % 8) < 5, 8'($urandom));
      end

      // Reset in the middle of a burst.
      for (int n = 0; n < 4; n++) step(1'b0, 8'h00);
      txconfig_bw = 2'd0; sys_bw_mode = 2'd0; config_mu_subband_present = 4'hF;
      config_gamma_rotation = 8'h00; n_tx = 4'd4; nhtp_4ch = 1'b0;
      step(1'b1, 8'h01);
      step(1'b1, 8'h01);
      chk("ntx4_i", nhtp_rdata_i, 256);
      step(1'b1, 8'h02);
      @(negedge clk);
      reset_n = 1'b0;
      nhtp_re = 1'b0;
      #1;
      chk("mid_rst_rvalid", nhtp_rvalid, 0);
      chk("mid_rst_i", nhtp_rdata_i, 0);
      chk("mid_rst_q", nhtp_rdata_q, 0);
      chk("mid_rst_addr_err", addr_err, 0);
      chk("mid_rst_cfg_err", cfg_err, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int n = 0; n < 5; n++) step(1'b0, 8'h00);
      for (int n = 0; n < 40; n++) begin
         rand_cfg();
         step(($urandom % 4) != 0, 8'($urandom));
      end
      for (int n = 0; n < 4; n++) step(1'b0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
